return_address_stack: RTL



---
 rtl/return_address_stack_pkg.sv | 38 +++
 rtl/return_address_stack_if.sv | 31 +++
 rtl/return_address_stack_storage.sv | 26 ++
 rtl/return_address_stack.sv | 121 ++++++++++++
 4 files changed

// File: rtl/return_address_stack_pkg.sv
// Shared RAS constants: overflow-mode codes, default geometry and the
// per-cycle operation decode used by the pointer/count logic.
package return_address_stack_pkg;

   localparam int RAS_MODE_WRAP = 0;
   localparam int RAS_MODE_DROP = 1;

   localparam int RAS_DEFAULT_DEPTH      = 8;
   localparam int RAS_DEFAULT_ADDR_WIDTH = 32;

   typedef enum logic [2:0] {
      RAS_OP_IDLE,
      RAS_OP_FLUSH,
      RAS_OP_PUSH,
      RAS_OP_POP,
      RAS_OP_REPLACE
   } ras_op_e;

   // Flush dominates; a simultaneous push and pop is a replace-in-place.
   function automatic ras_op_e ras_decode(input logic flush,
                                          input logic push,
                                          input logic pop);
      ras_op_e op;
      op = RAS_OP_IDLE;
      if (flush) begin
         op = RAS_OP_FLUSH;
      end else begin
         case ({push, pop})
            2'b10:   op = RAS_OP_PUSH;
            2'b01:   op = RAS_OP_POP;
            2'b11:   op = RAS_OP_REPLACE;
            default: op = RAS_OP_IDLE;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/return_address_stack_if.sv
// Fetch-side bundle of the return-address stack: control/data from the IFU
// (master) and the predicted target plus status back from the stack (slave).
interface return_address_stack_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   // Every input is sampled each posedge; there is no back-pressure, so
   // push/pop are single-cycle strobes that are always accepted.
   logic                  flush;
   logic                  push;
   logic [ADDR_WIDTH-1:0] push_addr;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] top_addr;
   logic                  top_valid;
   logic                  full;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, push, push_addr, pop,
      input  top_addr, top_valid, full, count, overflow, underflow
   );

   modport slave (
      input  flush, push, push_addr, pop,
      output top_addr, top_valid, full, count, overflow, underflow
   );
endinterface

// File: rtl/return_address_stack_storage.sv
// DEPTH x ADDR_WIDTH register array for the RAS: one synchronous write port,
// one asynchronous read port, contents deliberately left unreset.
module ras_storage #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 8,
   localparam int PW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [PW-1:0]         waddr,
   input  logic [ADDR_WIDTH-1:0] wdata,
   input  logic [PW-1:0]         raddr,
   output logic [ADDR_WIDTH-1:0] rdata
);

   logic [ADDR_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/return_address_stack.sv
// Return-address stack for the fetch path: jal/jalr push the link address,
// jr $ra pops, and the top entry is offered to the IFU as a predicted target.
module return_address_stack
   import return_address_stack_pkg::*;
#(
   parameter int ADDR_WIDTH    = RAS_DEFAULT_ADDR_WIDTH,
   parameter int DEPTH         = RAS_DEFAULT_DEPTH,
   parameter int OVERFLOW_MODE = RAS_MODE_WRAP
) (
   input  logic                  clk,
   input  logic                  reset_n,
   return_address_stack_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [PW-1:0]         tos_q, tos_d, tos_inc, tos_dec;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  is_full, is_empty;
   logic                  we;
   logic                  mem_we;
   logic [PW-1:0]         waddr;
   logic [ADDR_WIDTH-1:0] rdata;
   ras_op_e               op;

   assign op       = ras_decode(bus.flush, bus.push, bus.pop);
   assign is_full  = (cnt_q == CNT_FULL);
   assign is_empty = (cnt_q == '0);
   // Pointer wrap is plain truncation to PW bits.
   assign tos_inc  = tos_q + PW'(1);
   assign tos_dec  = tos_q - PW'(1);

   always_comb begin
      tos_d = tos_q;
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      we    = 1'b0;
      waddr = tos_inc;
      case (op)
         RAS_OP_FLUSH: begin
            cnt_d = '0;
         end
         RAS_OP_PUSH: begin
            if (!is_full) begin
               we    = 1'b1;
               tos_d = tos_inc;
               cnt_d = cnt_q + CW'(1);
            end else begin
               ovf_d = 1'b1;
               // In wrap mode tos+1 is the oldest slot, so it gets overwritten.
               if (OVERFLOW_MODE != RAS_MODE_DROP) begin
                  we    = 1'b1;
                  tos_d = tos_inc;
               end
            end
         end
         RAS_OP_POP: begin
            if (is_empty) begin
               unf_d = 1'b1;
            end else begin
               tos_d = tos_dec;
               cnt_d = cnt_q - CW'(1);
            end
         end
         RAS_OP_REPLACE: begin
            we = 1'b1;
            if (is_empty) begin
               unf_d = 1'b1;
               tos_d = tos_inc;
               cnt_d = CW'(1);
            end else begin
               waddr = tos_q;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tos_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         tos_q <= tos_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Gating with reset_n keeps unknown strobes during reset out of the array.
   assign mem_we = we & reset_n;

   ras_storage #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_storage (
      .clk   (clk),
      .we    (mem_we),
      .waddr (waddr),
      .wdata (bus.push_addr),
      .raddr (tos_q),
      .rdata (rdata)
   );

   assign bus.top_valid = !is_empty;
   assign bus.top_addr  = is_empty ? '0 : rdata;
   assign bus.full      = is_full;
   assign bus.count     = cnt_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;

endmodule
